// File: rtl/instruction_fetch_if.sv
// Instruction memory read bus between the fetch stage (master) and instruction memory (slave).
interface instruction_fetch_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] mem_addr;
    logic             mem_rd;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads the word at the current PC over a req/ack bus, latches it into the IR,
// and pulses o_pc_enable once per completed fetch. Handles branch flush and a wait-state timeout fault.
module instruction_fetch #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [WIDTH-1:0]    i_pc,
    input  logic                i_fetch_go,
    input  logic                i_flush,
    instruction_fetch_if.master mem,
    output logic [WIDTH-1:0]    o_ir,
    output logic                o_ir_valid,
    output logic                o_pc_enable,
    output logic                o_busy,
    output logic                o_fault
);
    localparam int unsigned CNT_W    = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem_addr;
    logic             r_mem_rd;
    logic [WIDTH-1:0] r_ir;
    logic             r_ir_valid;
    logic             r_pc_enable;
    logic             r_busy;
    logic             r_fault;
    logic [CNT_W-1:0] r_cnt;

    logic             w_timeout_hit;
    logic             w_cnt_sat;

    // Counter holds the number of no-ack cycles already seen; the next one at CNT_LAST is the TIMEOUT-th.
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(CNT_LAST));
    assign w_cnt_sat     = (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_pc_enable <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pc_enable <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_flush) begin
                        r_ir_valid <= 1'b0;
                    end else if (i_fetch_go) begin
                        r_mem_addr <= i_pc;
                        r_mem_rd   <= 1'b1;
                        r_ir_valid <= 1'b0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_ack) begin
                        r_mem_rd <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                        if (!i_flush) begin
                            r_ir        <= mem.mem_rdata;
                            r_ir_valid  <= 1'b1;
                            r_pc_enable <= 1'b1;
                        end
                    end else if (w_timeout_hit) begin
                        r_mem_rd <= 1'b0;
                        r_fault  <= 1'b1;
                        r_state  <= S_FAULT;
                    end else begin
                        if (!w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
                        if (i_flush) r_state <= S_DRAIN;
                    end
                end
                // Memory cannot abort, so a flushed request waits out its ack and drops the data.
                S_DRAIN: begin
                    if (mem.mem_ack) begin
                        r_mem_rd <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_timeout_hit) begin
                        r_mem_rd <= 1'b0;
                        r_fault  <= 1'b1;
                        r_state  <= S_FAULT;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    assign mem.mem_addr = r_mem_addr;
    assign mem.mem_rd   = r_mem_rd;
    assign o_ir         = r_ir;
    assign o_ir_valid   = r_ir_valid;
    assign o_pc_enable  = r_pc_enable;
    assign o_busy       = r_busy;
    assign o_fault      = r_fault;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one instance with TIMEOUT=15, one with TIMEOUT=4, shared stimulus.
module tb_instruction_fetch;
    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        fetch_go;
    logic        flush;
    logic        ack;
    logic [15:0] rdata;

    logic [15:0] a_ir, b_ir;
    logic        a_ir_valid, b_ir_valid;
    logic        a_pc_enable, b_pc_enable;
    logic        a_busy, b_busy;
    logic        a_fault, b_fault;

    int n_vec = 0;
    int n_bad = 0;

    instruction_fetch_if #(.WIDTH(16)) bus_a ();
    instruction_fetch_if #(.WIDTH(16)) bus_b ();

    assign bus_a.mem_ack   = ack;
    assign bus_a.mem_rdata = rdata;
    assign bus_b.mem_ack   = ack;
    assign bus_b.mem_rdata = rdata;

    instruction_fetch #(.WIDTH(16), .TIMEOUT(15)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_fetch_go(fetch_go), .i_flush(flush),
        .mem(bus_a.master), .o_ir(a_ir), .o_ir_valid(a_ir_valid), .o_pc_enable(a_pc_enable),
        .o_busy(a_busy), .o_fault(a_fault)
    );

    instruction_fetch #(.WIDTH(16), .TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_fetch_go(fetch_go), .i_flush(flush),
        .mem(bus_b.master), .o_ir(b_ir), .o_ir_valid(b_ir_valid), .o_pc_enable(b_pc_enable),
        .o_busy(b_busy), .o_fault(b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and checks happen 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = '0; fetch_go = 1'b0; flush = 1'b0; ack = 1'b0; rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mem_rd",   32'(bus_a.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
        check("rst_ir",       32'(a_ir), 32'd0);
        check("rst_busy",     32'(a_busy), 32'd0);
        check("rst_fault",    32'(a_fault), 32'd0);

        // Basic fetch
        pc = 16'h0010; fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        check("basic_c1_rd",   32'(bus_a.mem_rd), 32'd1);
        check("basic_c1_addr", 32'(bus_a.mem_addr), 32'h0010);
        check("basic_c1_busy", 32'(a_busy), 32'd1);
        tick();
        check("basic_c2_rd", 32'(bus_a.mem_rd), 32'd1);
        ack = 1'b1; rdata = 16'hA5C3;
        tick();
        ack = 1'b0;
        check("basic_c3_ir",    32'(a_ir), 32'hA5C3);
        check("basic_c3_valid", 32'(a_ir_valid), 32'd1);
        check("basic_c3_pcen",  32'(a_pc_enable), 32'd1);
        check("basic_c3_rd",    32'(bus_a.mem_rd), 32'd0);
        check("basic_c3_busy",  32'(a_busy), 32'd0);
        tick();
        check("basic_c4_pcen",  32'(a_pc_enable), 32'd0);
        check("basic_c4_valid", 32'(a_ir_valid), 32'd1);

        // Five wait states on the TIMEOUT=15 instance
        pc = 16'h0011; fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("wait_rd",   32'(bus_a.mem_rd), 32'd1);
            check("wait_addr", 32'(bus_a.mem_addr), 32'h0011);
            check("wait_pcen", 32'(a_pc_enable), 32'd0);
            tick();
        end
        check("wait_c6_rd", 32'(bus_a.mem_rd), 32'd1);
        ack = 1'b1; rdata = 16'h5A5A;
        tick();
        ack = 1'b0;
        check("wait_ir",    32'(a_ir), 32'h5A5A);
        check("wait_pcen",  32'(a_pc_enable), 32'd1);
        check("wait_fault", 32'(a_fault), 32'd0);
        tick();
        check("wait_pcen_off", 32'(a_pc_enable), 32'd0);

        // Flush together with fetch_go in IDLE: flush wins and clears ir_valid
        flush = 1'b1; fetch_go = 1'b1;
        tick();
        flush = 1'b0; fetch_go = 1'b0;
        check("idleflush_valid", 32'(a_ir_valid), 32'd0);
        check("idleflush_rd",    32'(bus_a.mem_rd), 32'd0);
        check("idleflush_busy",  32'(a_busy), 32'd0);

        // Flush in WAIT, ack later through DRAIN
        pc = 16'h0020; fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("drain_c2_busy", 32'(a_busy), 32'd1);
        check("drain_c2_rd",   32'(bus_a.mem_rd), 32'd1);
        tick();
        check("drain_c3_rd", 32'(bus_a.mem_rd), 32'd1);
        ack = 1'b1; rdata = 16'h1234;
        tick();
        ack = 1'b0;
        check("drain_c4_rd",    32'(bus_a.mem_rd), 32'd0);
        check("drain_c4_ir",    32'(a_ir), 32'h5A5A);
        check("drain_c4_valid", 32'(a_ir_valid), 32'd0);
        check("drain_c4_pcen",  32'(a_pc_enable), 32'd0);
        check("drain_c4_busy",  32'(a_busy), 32'd0);

        // Flush with ack in the same WAIT cycle
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0; flush = 1'b1; ack = 1'b1; rdata = 16'h4321;
        tick();
        flush = 1'b0; ack = 1'b0;
        check("flushack_rd",    32'(bus_a.mem_rd), 32'd0);
        check("flushack_busy",  32'(a_busy), 32'd0);
        check("flushack_ir",    32'(a_ir), 32'h5A5A);
        check("flushack_valid", 32'(a_ir_valid), 32'd0);
        check("flushack_pcen",  32'(a_pc_enable), 32'd0);
        tick();
        check("flushack_pcen2", 32'(a_pc_enable), 32'd0);

        // Reset while a request is outstanding
        pc = 16'h0033; fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        check("midrst_pre_rd", 32'(bus_a.mem_rd), 32'd1);
        do_reset();
        check("midrst_rd",     32'(bus_a.mem_rd), 32'd0);
        check("midrst_addr",   32'(bus_a.mem_addr), 32'd0);
        check("midrst_ir",     32'(a_ir), 32'd0);
        check("midrst_valid",  32'(a_ir_valid), 32'd0);
        check("midrst_pcen",   32'(a_pc_enable), 32'd0);
        check("midrst_busy",   32'(a_busy), 32'd0);
        check("midrst_fault",  32'(b_fault), 32'd0);

        // Timeout on the TIMEOUT=4 instance
        pc = 16'h0044; fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("to_rd",    32'(bus_b.mem_rd), 32'd1);
            check("to_fault", 32'(b_fault), 32'd0);
            tick();
        end
        check("to_c5_rd",    32'(bus_b.mem_rd), 32'd0);
        check("to_c5_fault", 32'(b_fault), 32'd1);
        check("to_c5_busy",  32'(b_busy), 32'd1);
        fetch_go = 1'b1; ack = 1'b1;
        tick();
        tick();
        fetch_go = 1'b0; ack = 1'b0;
        check("to_stuck_rd",    32'(bus_b.mem_rd), 32'd0);
        check("to_stuck_fault", 32'(b_fault), 32'd1);
        check("to_stuck_pcen",  32'(b_pc_enable), 32'd0);
        do_reset();
        check("to_rst_fault", 32'(b_fault), 32'd0);
        check("to_rst_busy",  32'(b_busy), 32'd0);

        // Ack on exactly the 4th wait cycle completes normally
        pc = 16'h0055; fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        tick();
        tick();
        tick();
        check("edge_c4_rd", 32'(bus_b.mem_rd), 32'd1);
        ack = 1'b1; rdata = 16'hBEEF;
        tick();
        ack = 1'b0;
        check("edge_pcen",  32'(b_pc_enable), 32'd1);
        check("edge_ir",    32'(b_ir), 32'hBEEF);
        check("edge_fault", 32'(b_fault), 32'd0);
        check("edge_busy",  32'(b_busy), 32'd0);

        // Back-to-back fetches with fetch_go and ack held high
        do_reset();
        pc = 16'h0040; fetch_go = 1'b1; ack = 1'b1; rdata = 16'h7700;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("b2b_pcen", 32'(a_pc_enable), ((c % 2) == 0) ? 32'd1 : 32'd0);
            check("b2b_rd",   32'(bus_a.mem_rd), ((c % 2) == 1) ? 32'd1 : 32'd0);
            if ((c % 2) == 1) check("b2b_addr", 32'(bus_a.mem_addr), 32'h0040);
            else              check("b2b_ir",   32'(a_ir), 32'h7700);
        end
        fetch_go = 1'b0; ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
